// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-unit inputs from ID/EX/MEM and the stall/flush controls it returns.
// The controller takes the slave side; the stage logic or bench drives the master side.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs_i;
  logic [REG_W-1:0] id_rt_i;
  logic             id_uses_rs_i;
  logic             id_uses_rt_i;
  logic             ex_memread_i;
  logic [REG_W-1:0] ex_rd_i;
  logic             ex_branch_taken_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             halt_i;
  logic             resume_i;
  logic             pc_write_o;
  logic             ifid_dhz_o;
  logic             ifid_chz_o;
  logic             idex_flush_o;
  logic             exmem_hold_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
           ex_branch_taken_i, mem_req_i, mem_ready_i, halt_i, resume_i,
    input  pc_write_o, ifid_dhz_o, ifid_chz_o, idex_flush_o, exmem_hold_o,
           state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
           ex_branch_taken_i, mem_req_i, mem_ready_i, halt_i, resume_i,
    output pc_write_o, ifid_dhz_o, ifid_chz_o, idex_flush_o, exmem_hold_o,
           state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait freezes and a drain-then-halt sequence, with saturating stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int REG_W     = 3,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk_i,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic load_use;
  logic mem_stall;
  logic flush_evt;
  logic pc_write, dhz, chz, idex_flush, exmem_hold;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // r0 is hardwired zero, so a load targeting it never blocks a consumer.
  assign load_use = hz.ex_memread_i && (hz.ex_rd_i != '0) &&
                    ((hz.id_uses_rs_i && (hz.id_rs_i == hz.ex_rd_i)) ||
                     (hz.id_uses_rt_i && (hz.id_rt_i == hz.ex_rd_i)));
  assign mem_stall = hz.mem_req_i && !hz.mem_ready_i;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    pc_write   = 1'b1;
    dhz        = 1'b0;
    chz        = 1'b0;
    idex_flush = 1'b0;
    exmem_hold = 1'b0;
    flush_evt  = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_write   = 1'b0;
          dhz        = 1'b1;
          exmem_hold = 1'b1;
          state_d    = MEM_WAIT;
        end else if (hz.ex_branch_taken_i) begin
          chz        = 1'b1;
          idex_flush = 1'b1;
          flush_evt  = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          dhz        = 1'b1;
          idex_flush = 1'b1;
        end else if (hz.halt_i) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end

      MEM_WAIT: begin
        if (!hz.mem_ready_i) begin
          pc_write   = 1'b0;
          dhz        = 1'b1;
          exmem_hold = 1'b1;
        end else begin
          state_d = RUN;
        end
      end

      DRAIN: begin
        // A memory wait freezes the whole pipe, including the drain count.
        if (mem_stall) begin
          pc_write   = 1'b0;
          dhz        = 1'b1;
          exmem_hold = 1'b1;
        end else begin
          chz = 1'b1;
          if (hz.ex_branch_taken_i) begin
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
          end else begin
            pc_write = 1'b0;
          end
          if (drain_q == DW'(DRAIN_CYC - 1)) state_d = HALTED;
          else                               drain_d = drain_q + 1'b1;
        end
      end

      HALTED: begin
        pc_write = 1'b0;
        chz      = 1'b1;
        if (hz.resume_i) state_d = RUN;
      end

      default: state_d = RUN;
    endcase

    // While in reset the front end is held empty.
    if (!rst_n) begin
      pc_write   = 1'b0;
      dhz        = 1'b0;
      chz        = 1'b1;
      idex_flush = 1'b1;
      exmem_hold = 1'b0;
      flush_evt  = 1'b0;
    end
  end

  assign stall_d = dhz       ? sat_inc(stall_q) : stall_q;
  assign flush_d = flush_evt ? sat_inc(flush_q) : flush_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.pc_write_o   = pc_write;
  assign hz.ifid_dhz_o   = dhz;
  assign hz.ifid_chz_o   = chz;
  assign hz.idex_flush_o = idex_flush;
  assign hz.exmem_hold_o = exmem_hold;
  assign hz.state_o      = state_q;
  assign hz.stall_cnt_o  = stall_q;
  assign hz.flush_cnt_o  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors with literal checks, plus a per-cycle
// comparison against a rule-level model of the controller.
module tb_pipe_hazard_ctrl;
  localparam int     REG_W     = 3;
  localparam int     CNT_W     = 16;
  localparam int     DRAIN_CYC = 3;
  localparam longint CMAX      = (64'd1 << CNT_W) - 1;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus();

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .hz   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: state 0 run, 1 memory wait, 2 draining, 3 halted.
  int     ms = 0, md = 0, n_ms = 0, n_md = 0;
  longint msc = 0, mfc = 0, n_sc = 0, n_fc = 0;
  logic   e_pc, e_dhz, e_chz, e_fl, e_hold;
  logic   m_lu, m_mst;

  always @(negedge clk_i) begin
    m_lu  = bus.ex_memread_i && (bus.ex_rd_i != 0) &&
            ((bus.id_uses_rs_i && bus.id_rs_i == bus.ex_rd_i) ||
             (bus.id_uses_rt_i && bus.id_rt_i == bus.ex_rd_i));
    m_mst = bus.mem_req_i && !bus.mem_ready_i;
    n_ms = ms; n_md = md; n_sc = msc; n_fc = mfc;
    {e_pc, e_dhz, e_chz, e_fl, e_hold} = 5'b10000;
    if (!rst_n) begin
      {e_pc, e_dhz, e_chz, e_fl, e_hold} = 5'b00110;
    end else if (ms == 0) begin
      if (m_mst) begin
        {e_pc, e_dhz, e_chz, e_fl, e_hold} = 5'b01001; n_ms = 1;
      end else if (bus.ex_branch_taken_i) begin
        {e_pc, e_dhz, e_chz, e_fl, e_hold} = 5'b10110; n_fc = mfc + 1;
      end else if (m_lu) begin
        {e_pc, e_dhz, e_chz, e_fl, e_hold} = 5'b01010;
      end else if (bus.halt_i) begin
        n_ms = 2; n_md = 0;
      end
    end else if (ms == 1) begin
      if (!bus.mem_ready_i) {e_pc, e_dhz, e_chz, e_fl, e_hold} = 5'b01001;
      else n_ms = 0;
    end else if (ms == 2) begin
      if (m_mst) begin
        {e_pc, e_dhz, e_chz, e_fl, e_hold} = 5'b01001;
      end else begin
        if (bus.ex_branch_taken_i) begin
          {e_pc, e_dhz, e_chz, e_fl, e_hold} = 5'b10110; n_fc = mfc + 1;
        end else begin
          {e_pc, e_dhz, e_chz, e_fl, e_hold} = 5'b00100;
        end
        n_md = md + 1;
        if (n_md == DRAIN_CYC) n_ms = 3;
      end
    end else begin
      {e_pc, e_dhz, e_chz, e_fl, e_hold} = 5'b00100;
      if (bus.resume_i) n_ms = 0;
    end
    if (e_dhz) n_sc = msc + 1;
    if (n_sc > CMAX) n_sc = CMAX;
    if (n_fc > CMAX) n_fc = CMAX;

    chk("m_state",     bus.state_o,      ms);
    chk("m_pc_write",  bus.pc_write_o,   e_pc);
    chk("m_dhz",       bus.ifid_dhz_o,   e_dhz);
    chk("m_chz",       bus.ifid_chz_o,   e_chz);
    chk("m_idex_fl",   bus.idex_flush_o, e_fl);
    chk("m_exmem_hld", bus.exmem_hold_o, e_hold);
    chk("m_stall_cnt", bus.stall_cnt_o,  msc);
    chk("m_flush_cnt", bus.flush_cnt_o,  mfc);
  end

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ms <= 0; md <= 0; msc <= 0; mfc <= 0;
    end else begin
      ms <= n_ms; md <= n_md; msc <= n_sc; mfc <= n_fc;
    end
  end

  task automatic idle();
    bus.id_rs_i = '0; bus.id_rt_i = '0; bus.id_uses_rs_i = 1'b0; bus.id_uses_rt_i = 1'b0;
    bus.ex_memread_i = 1'b0; bus.ex_rd_i = '0; bus.ex_branch_taken_i = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_ready_i = 1'b0; bus.halt_i = 1'b0; bus.resume_i = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk_i); #1;
  endtask

  task automatic mid();
    @(negedge clk_i); #1;
  endtask

  task automatic set_lu(input logic [REG_W-1:0] rd);
    bus.ex_memread_i = 1'b1; bus.ex_rd_i = rd; bus.id_uses_rs_i = 1'b1; bus.id_rs_i = rd;
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0; nxt(); rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    mid(); mid();
    chk("rst_state", bus.state_o, 0);
    chk("rst_pc", bus.pc_write_o, 0);
    chk("rst_dhz", bus.ifid_dhz_o, 0);
    chk("rst_chz", bus.ifid_chz_o, 1);
    chk("rst_idex", bus.idex_flush_o, 1);
    chk("rst_hold", bus.exmem_hold_o, 0);
    chk("rst_stall", bus.stall_cnt_o, 0);
    chk("rst_flush", bus.flush_cnt_o, 0);
    nxt(); rst_n = 1'b1;
    mid();
    chk("run_pc", bus.pc_write_o, 1);
    chk("run_chz", bus.ifid_chz_o, 0);

    // Load-use through rs, then the same pattern against r0.
    nxt(); set_lu(3'd3);
    mid();
    chk("lu_pc", bus.pc_write_o, 0);
    chk("lu_dhz", bus.ifid_dhz_o, 1);
    chk("lu_idex", bus.idex_flush_o, 1);
    chk("lu_stall0", bus.stall_cnt_o, 0);
    nxt(); set_lu(3'd0);
    mid();
    chk("lu_stall1", bus.stall_cnt_o, 1);
    chk("r0_dhz", bus.ifid_dhz_o, 0);
    chk("r0_pc", bus.pc_write_o, 1);
    // Load-use through rt only.
    nxt(); idle(); bus.ex_memread_i = 1'b1; bus.ex_rd_i = 3'd5;
    bus.id_uses_rt_i = 1'b1; bus.id_rt_i = 3'd5; bus.id_rs_i = 3'd5;
    mid();
    chk("lurt_dhz", bus.ifid_dhz_o, 1);
    nxt(); bus.id_uses_rt_i = 1'b0;
    mid();
    chk("lu_unused_dhz", bus.ifid_dhz_o, 0);

    // Branch and load-use together: the flush wins.
    nxt(); do_reset(); set_lu(3'd3); bus.ex_branch_taken_i = 1'b1;
    mid();
    chk("br_chz", bus.ifid_chz_o, 1);
    chk("br_idex", bus.idex_flush_o, 1);
    chk("br_pc", bus.pc_write_o, 1);
    chk("br_dhz", bus.ifid_dhz_o, 0);
    nxt(); idle();
    mid();
    chk("br_flush_cnt", bus.flush_cnt_o, 1);
    chk("br_stall_cnt", bus.stall_cnt_o, 0);

    // Four cycles of memory wait, then ready.
    nxt(); do_reset(); bus.mem_req_i = 1'b1; bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("mw_state", bus.state_o, (i == 0) ? 0 : 1);
      chk("mw_hold", bus.exmem_hold_o, 1);
      nxt();
    end
    bus.mem_ready_i = 1'b1;
    mid();
    chk("mw_rdy_state", bus.state_o, 1);
    chk("mw_rdy_hold", bus.exmem_hold_o, 0);
    chk("mw_rdy_pc", bus.pc_write_o, 1);
    nxt(); idle();
    mid();
    chk("mw_done_state", bus.state_o, 0);
    chk("mw_stall_cnt", bus.stall_cnt_o, 4);

    // Reset in the middle of a memory wait.
    nxt(); bus.mem_req_i = 1'b1;
    nxt();
    mid();
    chk("rmw_pre_state", bus.state_o, 1);
    rst_n = 1'b0; #1;
    chk("rmw_state", bus.state_o, 0);
    idle(); nxt(); rst_n = 1'b1;
    mid();
    chk("rmw_after_state", bus.state_o, 0);

    // Halt: three drain cycles, then halted until resume.
    nxt(); bus.halt_i = 1'b1;
    mid();
    chk("h_req_state", bus.state_o, 0);
    nxt();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("h_drain_state", bus.state_o, 2);
      chk("h_drain_chz", bus.ifid_chz_o, 1);
      chk("h_drain_pc", bus.pc_write_o, 0);
      nxt();
    end
    mid();
    chk("h_halted_state", bus.state_o, 3);
    chk("h_halted_chz", bus.ifid_chz_o, 1);
    nxt(); bus.halt_i = 1'b0;
    nxt(); bus.resume_i = 1'b1;
    mid();
    chk("h_resume_state", bus.state_o, 3);
    nxt(); bus.resume_i = 1'b0;
    mid();
    chk("h_run_state", bus.state_o, 0);
    chk("h_run_pc", bus.pc_write_o, 1);

    // Drain with a memory freeze and a branch inside it.
    nxt(); do_reset(); bus.halt_i = 1'b1;
    nxt(); bus.halt_i = 1'b0; bus.mem_req_i = 1'b1;
    mid();
    chk("dm_state", bus.state_o, 2);
    chk("dm_hold", bus.exmem_hold_o, 1);
    chk("dm_dhz", bus.ifid_dhz_o, 1);
    nxt();
    mid();
    chk("dm_frozen_state", bus.state_o, 2);
    nxt(); bus.mem_req_i = 1'b0; bus.ex_branch_taken_i = 1'b1;
    mid();
    chk("db_pc", bus.pc_write_o, 1);
    chk("db_idex", bus.idex_flush_o, 1);
    nxt(); bus.ex_branch_taken_i = 1'b0;
    mid();
    chk("db_state1", bus.state_o, 2);
    nxt();
    mid();
    chk("db_state2", bus.state_o, 2);
    nxt();
    mid();
    chk("db_halted", bus.state_o, 3);
    chk("db_flush_cnt", bus.flush_cnt_o, 1);
    chk("db_stall_cnt", bus.stall_cnt_o, 2);

    // Reset in the middle of a drain.
    nxt(); bus.resume_i = 1'b1;
    nxt(); bus.resume_i = 1'b0; bus.halt_i = 1'b1;
    nxt(); bus.halt_i = 1'b0;
    mid();
    chk("rd_pre_state", bus.state_o, 2);
    rst_n = 1'b0; #1;
    chk("rd_state", bus.state_o, 0);
    chk("rd_stall", bus.stall_cnt_o, 0);
    chk("rd_flush", bus.flush_cnt_o, 0);
    nxt(); rst_n = 1'b1;
    mid();
    chk("rd_after_state", bus.state_o, 0);

    // Stall counter saturation.
    nxt(); set_lu(3'd2);
    repeat (70000) nxt();
    mid();
    chk("sat_stall", bus.stall_cnt_o, 16'hFFFF);
    nxt();
    mid();
    chk("sat_hold", bus.stall_cnt_o, 16'hFFFF);
    chk("sat_dhz", bus.ifid_dhz_o, 1);
    nxt(); idle();
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 3; register-index width.
REQ-002 SHALL have parameter CNT_W, default 16; statistics counter width.
REQ-003 SHALL have parameter DRAIN_CYC, default 3; bubble cycles inserted before HALTED.
REQ-004 SHALL have reset rst_n, asynchronous, active-low, and clock clk_i.
REQ-005 SHALL provide the following ports, one per line:
  clk_i  in  1  clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  id_rs_i  in  REG_W  source register A of the instruction in ID
  id_rt_i  in  REG_W  source register B of the instruction in ID
  id_uses_rs_i  in  1  ID instruction reads rs
  id_uses_rt_i  in  1  ID instruction reads rt
  ex_memread_i  in  1  EX instruction is a load
  ex_rd_i  in  REG_W  EX destination register
  ex_branch_taken_i  in  1  branch resolved taken in EX
  mem_req_i  in  1  MEM stage is accessing data memory
  mem_ready_i  in  1  data memory completes this cycle
  halt_i  in  1  level request to drain and halt the pipe
  resume_i  in  1  restart from HALTED
  pc_write_o  out  1  PC register may update
  ifid_dhz_o  out  1  IF/ID hold (stall)
  ifid_chz_o  out  1  IF/ID load NOP (flush; wins over hold in IF/ID)
  idex_flush_o  out  1  ID/EX loads bubble
  exmem_hold_o  out  1  EX/MEM and MEM/WB hold
  state_o  out  2  FSM state
  stall_cnt_o  out  CNT_W  stall-cycle count
  flush_cnt_o  out  CNT_W  branch-flush count

Function
REQ-006 SHALL implement FSM states RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3; state_o SHALL equal the current state.
REQ-007 SHALL derive all control outputs combinationally from state and current inputs (Mealy); state and counters SHALL be registered.
REQ-008 SHALL define load_use = ex_memread_i & (ex_rd_i!=0) & ((id_uses_rs_i & id_rs_i==ex_rd_i) | (id_uses_rt_i & id_rt_i==ex_rd_i)); r0 never creates a hazard.
REQ-009 SHALL define mem_stall = mem_req_i & ~mem_ready_i.
REQ-010 SHALL, in RUN, apply priority mem_stall > ex_branch_taken_i > load_use > halt_i > normal.
REQ-011 SHALL, on mem_stall (RUN or DRAIN): pc_write=0, dhz=1, chz=0, idex_flush=0, exmem_hold=1; RUN goes to MEM_WAIT; DRAIN stays and freezes its counter.
REQ-012 SHALL, in MEM_WAIT: hold the same freeze outputs while mem_ready_i=0; when mem_ready_i=1 drive normal outputs and return to RUN next cycle; branch, load_use, halt_i ignored.
REQ-013 SHALL, on branch taken (RUN or DRAIN, no mem_stall): pc_write=1, chz=1, idex_flush=1, dhz=0; flush_cnt increments.
REQ-014 SHALL, on load_use in RUN: pc_write=0, dhz=1, chz=0, idex_flush=1; stall_cnt increments; state stays RUN.
REQ-015 SHALL, on halt_i in RUN with no higher event: enter DRAIN next cycle with drain counter 0.
REQ-016 SHALL, in DRAIN without mem_stall: pc_write=0 (except REQ-013), chz=1, idex_flush=0 (except REQ-013); counter increments; after DRAIN_CYC counted cycles go to HALTED.
REQ-017 SHALL, in HALTED: pc_write=0, chz=1, others 0; resume_i=1 returns to RUN next cycle; halt_i ignored there.
REQ-018 SHALL, in normal RUN: pc_write=1, all other control outputs 0.
REQ-019 SHALL increment stall_cnt_o on every cycle with ifid_dhz_o=1; both counters SHALL saturate at all-ones, never wrap.

Reset
REQ-020 SHALL, while rst_n=0, force state RUN, drain counter 0, both counters 0, and outputs pc_write=0, dhz=0, chz=1, idex_flush=1, exmem_hold=0.
REQ-021 SHALL, when rst_n asserts mid-MEM_WAIT or mid-DRAIN, abandon the operation immediately; first cycle after release is RUN.

Verification
REQ-022 Load-use: ex_memread=1, ex_rd=3, id_uses_rs=1, id_rs=3 for one cycle -> pc_write=0, dhz=1, idex_flush=1, stall_cnt 0->1; ex_rd=0 same stimulus -> no stall.
REQ-023 Branch + load_use same cycle -> chz=1, idex_flush=1, pc_write=1, dhz=0; flush_cnt=1, stall_cnt=0.
REQ-024 mem_req=1, mem_ready=0 for 4 cycles, then ready -> state_o=1 for 4 cycles, exmem_hold=1, stall_cnt=4, state_o=0 after.
REQ-025 halt_i=1 in RUN -> state_o 2 for 3 cycles with chz=1, then 3; resume_i pulse -> state_o=0 next cycle.
REQ-026 Force 70000 load_use cycles (CNT_W=16) -> stall_cnt_o=16'hFFFF held; rst_n low mid-DRAIN -> state_o=0, counters 0.
